// File: rtl/serial_subtractor_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level full-subtractor cell: diff = a ^ b ^ b_in, borrow out when a < b + b_in.
module full_subtractor (
    output logic diff,
    output logic b_out,
    input  logic a,
    input  logic b,
    input  logic b_in
);

    logic w_axb;
    logic w_na;
    logic w_naxb;
    logic w_t0;
    logic w_t1;

    xor g_x0 (w_axb, a, b);
    xor g_x1 (diff, w_axb, b_in);
    not g_n0 (w_na, a);
    and g_a0 (w_t0, w_na, b);
    not g_n1 (w_naxb, w_axb);
    and g_a1 (w_t1, w_naxb, b_in);
    or  g_o0 (b_out, w_t0, w_t1);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic             r_sa;
    logic             r_sb;
    logic             r_borrow;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_ovf;
    logic             w_d;
    logic             w_bo;

    full_subtractor u_cell (
        .diff  (w_d),
        .b_out (w_bo),
        .a     (r_ra[0]),
        .b     (r_rb[0]),
        .b_in  (r_borrow)
    );

    // Result bits enter the vacated top of the minuend register, so r_ra doubles as the result shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ra         <= {WIDTH{1'b0}};
            r_rb         <= {WIDTH{1'b0}};
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_borrow     <= 1'b0;
            r_count      <= {CW{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= {WIDTH{1'b0}};
            r_borrow_out <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ra     <= a;
                        r_rb     <= b;
                        r_sa     <= a[WIDTH-1];
                        r_sb     <= b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_count  <= {CW{1'b0}};
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_ra     <= {w_d, r_ra[WIDTH-1:1]};
                    r_rb     <= {1'b0, r_rb[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    r_count  <= r_count + ONE;
                    if (r_count == LAST) begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_diff       <= {w_d, r_ra[WIDTH-1:1]};
                        r_borrow_out <= w_bo;
                        r_ovf        <= (r_sa != r_sb) && (w_d != r_sa);
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=3) and its cell.
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bo8;
    logic       ovf8;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       busy3;
    logic       done3;
    logic [2:0] diff3;
    logic       bo3;
    logic       ovf3;

    logic fs_a;
    logic fs_b;
    logic fs_bin;
    logic fs_d;
    logic fs_bo;

    int n_tests;
    int n_fail;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .ovf        (ovf8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .start      (start3),
        .a          (a3),
        .b          (b3),
        .busy       (busy3),
        .done       (done3),
        .diff       (diff3),
        .borrow_out (bo3),
        .ovf        (ovf3)
    );

    full_subtractor u_fs (
        .diff  (fs_d),
        .b_out (fs_bo),
        .a     (fs_a),
        .b     (fs_b),
        .b_in  (fs_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] ed, input logic ebo, input logic eovf,
                           input logic [7:0] held, input string tag);
        int lat;
        int busy_cnt;
        a8 = ia;
        b8 = ib;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~ia;
        b8 = ~ib;
        check({tag, "_held"}, {24'd0, diff8}, {24'd0, held});
        busy_cnt = busy8 ? 1 : 0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy8) busy_cnt++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_diff"}, {24'd0, diff8}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, bo8}, {31'd0, ebo});
        check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eovf});
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_diff_hold"}, {24'd0, diff8}, {24'd0, ed});
    endtask

    task automatic run_op3(input logic [2:0] ia, input logic [2:0] ib);
        int lat;
        int sa;
        int sb;
        int res;
        logic [2:0] ed;
        logic eovf;
        sa = (ia >= 3'd4) ? int'(ia) - 8 : int'(ia);
        sb = (ib >= 3'd4) ? int'(ib) - 8 : int'(ib);
        res = sa - sb;
        eovf = (res < -4) || (res > 3);
        ed = ia - ib;
        a3 = ia;
        b3 = ib;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 0;
        while (!done3 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("w3_diff_%0d_%0d", ia, ib), {29'd0, diff3}, {29'd0, ed});
        check($sformatf("w3_borrow_%0d_%0d", ia, ib), {31'd0, bo3}, {31'd0, (ia < ib)});
        check($sformatf("w3_ovf_%0d_%0d", ia, ib), {31'd0, ovf3}, {31'd0, eovf});
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int gap;
        int r;
        logic [2:0] v;
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        start8 = 1'b0;
        start3 = 1'b0;
        a8 = 8'd0;
        b8 = 8'd0;
        a3 = 3'd0;
        b3 = 3'd0;
        fs_a = 1'b0;
        fs_b = 1'b0;
        fs_bin = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_diff", {24'd0, diff8}, 32'd0);
        check("rst_borrow", {31'd0, bo8}, 32'd0);
        check("rst_ovf", {31'd0, ovf8}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 8'h00, "op_5m3");
        run_op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 8'h02, "op_3m5");
        run_op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 8'hFE, "op_80m01");
        run_op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 8'h7F, "op_7Fm FF");

        // Full-subtractor cell truth table against integer arithmetic.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            fs_a = v[2];
            fs_b = v[1];
            fs_bin = v[0];
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            check($sformatf("fs_diff_%0d", i), {31'd0, fs_d}, {31'd0, r[0]});
            check($sformatf("fs_borrow_%0d", i), {31'd0, fs_bo}, {31'd0, (r < 0)});
        end
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                run_op3(3'(i), 3'(j));
            end
        end

        // Start held high with operands changing after capture.
        a8 = 8'h20;
        b8 = 8'h05;
        start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'hFF;
        b8 = 8'h00;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", lat, 8);
        check("hold_diff", {24'd0, diff8}, 32'h1B);
        a8 = 8'h0A;
        b8 = 8'h03;
        @(posedge clk); #1;
        check("hold_idle_busy", {31'd0, busy8}, 32'd0);
        check("hold_idle_done", {31'd0, done8}, 32'd0);
        @(posedge clk); #1;
        check("hold_reaccept", {31'd0, busy8}, 32'd1);
        start8 = 1'b0;
        a8 = 8'h00;
        b8 = 8'h00;
        gap = 2;
        while (!done8 && gap < 30) begin
            @(posedge clk); #1;
            gap++;
        end
        check("hold_done_gap", gap, 10);
        check("hold_diff2", {24'd0, diff8}, 32'h07);
        @(posedge clk); #1;

        // Asynchronous reset four cycles into SHIFT.
        a8 = 8'h55;
        b8 = 8'h11;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy8}, 32'd0);
        check("arst_done", {31'd0, done8}, 32'd0);
        check("arst_diff", {24'd0, diff8}, 32'd0);
        check("arst_borrow", {31'd0, bo8}, 32'd0);
        check("arst_ovf", {31'd0, ovf8}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done8) check("arst_no_done", {31'd0, done8}, 32'd0);
        end
        run_op8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 8'h00, "op_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
